// File: rtl/axi_burst_scheduler_if.sv
// Request/command bundle between the burst scheduler and the blocks around it:
// the three CMOS write paths, the video read path and the AXI master engine.
// The master modport is the scheduler's view; slave is the environment's view.
interface axi_burst_scheduler_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [2:0]            wr_req;
  logic [2:0]            wr_frame_start;
  logic                  rd_req;
  logic                  rd_urgent;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [2:0]            wr_grant;
  logic                  rd_grant;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_is_read;
  logic [1:0]            cmd_ch;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_done;
  logic [2:0]            rd_bank;
  logic [2:0]            overrun;

  modport master (
    input  wr_req, wr_frame_start, rd_req, rd_urgent, rd_addr, cmd_ready, cmd_done,
    output wr_grant, rd_grant, cmd_valid, cmd_is_read, cmd_ch, cmd_addr, rd_bank, overrun
  );

  modport slave (
    output wr_req, wr_frame_start, rd_req, rd_urgent, rd_addr, cmd_ready, cmd_done,
    input  wr_grant, rd_grant, cmd_valid, cmd_is_read, cmd_ch, cmd_addr, rd_bank, overrun
  );
endinterface

// File: rtl/axi_burst_scheduler.sv
// Burst scheduler sharing one AXI-FULL master between three CMOS write
// channels and the video read path. It issues one burst command at a time,
// generates per-channel write addresses inside double-buffered frame banks and
// reports to the read path which bank of each channel holds a complete frame.
module axi_burst_scheduler #(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h10000000,
  parameter int          C_M_AXI_ADDR_WIDTH         = 32,
  parameter int          C_M_AXI_DATA_WIDTH         = 128,
  parameter int          C_M_AXI_BURST_LEN          = 16,
  parameter int unsigned FRAME_BYTES                = 4147200,
  parameter logic [31:0] BANK_STRIDE                = 32'h00400000,
  parameter logic [31:0] CH_STRIDE                  = 32'h00800000
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  rst,
  axi_burst_scheduler_if.master bus
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned BURST_BYTES_I = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;
  localparam logic [AW-1:0] BURST_BYTES = AW'(BURST_BYTES_I);
  localparam logic [AW-1:0] FRAME_LIM   = AW'(FRAME_BYTES);
  localparam logic [AW-1:0] BASE_A      = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
  localparam logic [AW-1:0] BANK_A      = AW'(BANK_STRIDE);
  localparam logic [AW-1:0] CH_A        = AW'(CH_STRIDE);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [2:0]      wr_grant_q, wr_grant_d;
  logic            rd_grant_q, rd_grant_d;
  logic            cmd_is_read_q, cmd_is_read_d;
  logic [1:0]      cmd_ch_q, cmd_ch_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [AW-1:0]   offset_q [3];
  logic [AW-1:0]   offset_d [3];
  logic [2:0]      bank_q, bank_d;
  logic [2:0]      rd_bank_q, rd_bank_d;
  logic [2:0]      overrun_q, overrun_d;
  logic [2:0]      pend_q, pend_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;

  logic [2:0]      apply_fs;
  logic [2:0]      swap_fs;
  logic [2:0]      eff_bank;
  logic [AW-1:0]   eff_offset [3];
  logic [AW-1:0]   wr_addr [3];
  logic [2:0]      eligible;
  logic [3:0]      elig_ext;
  logic            pick_valid;
  logic [1:0]      pick_ch;
  logic [AW-1:0]   pick_addr;

  // Channel index k steps after the round-robin pointer, wrapped into 0..2.
  function automatic logic [1:0] rr_index(input logic [1:0] ptr, input logic [1:0] k);
    logic [2:0] sum;
    sum = {1'b0, ptr} + {1'b0, k};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  // Frame-start bookkeeping: a pulse for an in-flight channel is parked until its
  // grant drops; otherwise the bank swap and offset clear are folded into
  // "effective" values so an arbitration decision in the same cycle already
  // addresses the new frame.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      apply_fs[c]   = (bus.wr_frame_start[c] | pend_q[c]) & ~wr_grant_q[c];
      pend_d[c]     = wr_grant_q[c] & (pend_q[c] | bus.wr_frame_start[c]);
      swap_fs[c]    = apply_fs[c] && (offset_q[c] != '0);
      eff_bank[c]   = bank_q[c] ^ swap_fs[c];
      rd_bank_d[c]  = swap_fs[c] ? bank_q[c] : rd_bank_q[c];
      eff_offset[c] = apply_fs[c] ? '0 : offset_q[c];
      overrun_d[c]  = overrun_q[c] | (bus.wr_req[c] && (eff_offset[c] == FRAME_LIM));
      eligible[c]   = bus.wr_req[c] && !overrun_q[c] && (eff_offset[c] < FRAME_LIM);
      wr_addr[c]    = BASE_A + (AW'(c) * CH_A) + (eff_bank[c] ? BANK_A : '0) + eff_offset[c];
    end
  end

  // Round-robin pick: the first eligible writer at or after the pointer wins.
  always_comb begin
    elig_ext   = {1'b0, eligible};
    pick_valid = 1'b0;
    pick_ch    = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (elig_ext[rr_index(rr_ptr_q, 2'(k))]) begin
        pick_valid = 1'b1;
        pick_ch    = rr_index(rr_ptr_q, 2'(k));
      end
    end
    case (pick_ch)
      2'd0:    pick_addr = wr_addr[0];
      2'd1:    pick_addr = wr_addr[1];
      default: pick_addr = wr_addr[2];
    endcase
  end

  // Next-state logic: arbitrate in IDLE, hold the command through the ISSUE
  // handshake (advancing the write offset), then wait in BUSY for completion.
  always_comb begin
    state_d       = state_q;
    wr_grant_d    = wr_grant_q;
    rd_grant_d    = rd_grant_q;
    cmd_is_read_d = cmd_is_read_q;
    cmd_ch_d      = cmd_ch_q;
    cmd_addr_d    = cmd_addr_q;
    rr_ptr_d      = rr_ptr_q;
    bank_d        = eff_bank;
    for (int c = 0; c < 3; c++) offset_d[c] = eff_offset[c];

    case (state_q)
      IDLE: begin
        if ((bus.rd_urgent && bus.rd_req) || (!pick_valid && bus.rd_req)) begin
          state_d       = ISSUE;
          rd_grant_d    = 1'b1;
          cmd_is_read_d = 1'b1;
          cmd_ch_d      = 2'd3;
          cmd_addr_d    = bus.rd_addr;
        end else if (pick_valid) begin
          state_d       = ISSUE;
          wr_grant_d    = 3'b001 << pick_ch;
          cmd_is_read_d = 1'b0;
          cmd_ch_d      = pick_ch;
          cmd_addr_d    = pick_addr;
          rr_ptr_d      = rr_index(pick_ch, 2'd1);
        end
      end
      ISSUE: begin
        if (bus.cmd_ready) begin
          state_d = BUSY;
          for (int c = 0; c < 3; c++) begin
            if (!cmd_is_read_q && (cmd_ch_q == 2'(c))) offset_d[c] = eff_offset[c] + BURST_BYTES;
          end
        end
      end
      BUSY: begin
        if (bus.cmd_done) begin
          state_d    = IDLE;
          wr_grant_d = 3'b000;
          rd_grant_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge M_AXI_ACLK) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_grant_q    <= '0;
      rd_grant_q    <= 1'b0;
      cmd_is_read_q <= 1'b0;
      cmd_ch_q      <= '0;
      cmd_addr_q    <= '0;
      bank_q        <= '0;
      rd_bank_q     <= '0;
      overrun_q     <= '0;
      pend_q        <= '0;
      rr_ptr_q      <= '0;
      for (int c = 0; c < 3; c++) offset_q[c] <= '0;
    end else begin
      state_q       <= state_d;
      wr_grant_q    <= wr_grant_d;
      rd_grant_q    <= rd_grant_d;
      cmd_is_read_q <= cmd_is_read_d;
      cmd_ch_q      <= cmd_ch_d;
      cmd_addr_q    <= cmd_addr_d;
      bank_q        <= bank_d;
      rd_bank_q     <= rd_bank_d;
      overrun_q     <= overrun_d;
      pend_q        <= pend_d;
      rr_ptr_q      <= rr_ptr_d;
      for (int c = 0; c < 3; c++) offset_q[c] <= offset_d[c];
    end
  end

  assign bus.wr_grant    = wr_grant_q;
  assign bus.rd_grant    = rd_grant_q;
  assign bus.cmd_valid   = (state_q == ISSUE);
  assign bus.cmd_is_read = cmd_is_read_q;
  assign bus.cmd_ch      = cmd_ch_q;
  assign bus.cmd_addr    = cmd_addr_q;
  assign bus.rd_bank     = rd_bank_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: doc/axi_burst_scheduler.md
Name: axi_burst_scheduler

Overview:
- Shares the single AXI-FULL master between the three CMOS write paths and the video read path.
- Grants one burst at a time and issues a command to the AXI master engine: direction, channel and start address.
- Generates the per-channel write addresses and manages double-buffered frame banks.
- Tells the read path which bank of each channel is complete and safe to display.

Parameters:
C_M_TARGET_SLAVE_BASE_ADDR, 32'h10000000, base address of all frame buffers
C_M_AXI_ADDR_WIDTH, 32, address width
C_M_AXI_DATA_WIDTH, 128, AXI data width; BURST_BYTES = C_M_AXI_BURST_LEN*C_M_AXI_DATA_WIDTH/8
C_M_AXI_BURST_LEN, 16, beats per burst (default gives BURST_BYTES = 256)
FRAME_BYTES, 4147200, bytes per channel frame; must be a multiple of BURST_BYTES
BANK_STRIDE, 32'h00400000, byte offset between bank 0 and bank 1
CH_STRIDE, 32'h00800000, byte offset between channels

Ports:
M_AXI_ACLK  in  1  sole clock
rst  in  1  synchronous, active-high reset
wr_req  in  3  per-CMOS channel: write FIFO holds >= one burst
wr_frame_start  in  3  per-channel 1-cycle pulse, already synchronised to M_AXI_ACLK
rd_req  in  1  read FIFO has room for one burst
rd_urgent  in  1  read FIFO below low watermark
rd_addr  in  C_M_AXI_ADDR_WIDTH  read burst address supplied by the read path
wr_grant  out  3  one-hot; held from command issue until cmd_done
rd_grant  out  1  held from command issue until cmd_done
cmd_valid  out  1  command valid to the AXI master engine
cmd_ready  in  1  engine accepts the command
cmd_is_read  out  1  1 = AR burst, 0 = AW burst
cmd_ch  out  2  0..2 = write channel, 3 = read
cmd_addr  out  C_M_AXI_ADDR_WIDTH  burst start address
cmd_done  in  1  1-cycle pulse: last beat accepted (write: B response received)
rd_bank  out  3  per channel, last completed write bank
overrun  out  3  sticky per channel: frame exceeded FRAME_BYTES

Behaviour:
- Reset values: all outputs 0. All offsets 0. All write banks 0. Round-robin pointer = 0. State IDLE.
- FSM states: IDLE, ISSUE, BUSY.
- IDLE: evaluate requests in the same cycle as the decision. Priority order:
  1. rd_urgent && rd_req
  2. round-robin among eligible writers, starting at the pointer
  3. rd_req
- Writer eligibility: wr_req[c]=1 and overrun[c]=0 and offset[c] < FRAME_BYTES.
- IDLE -> ISSUE on any grant. The following are registered in that cycle: grant, cmd_is_read, cmd_ch, cmd_addr.
- cmd_valid=1 in ISSUE. Latency: request sampled in IDLE -> cmd_valid high on the next cycle.
- ISSUE: hold cmd_* stable until cmd_valid && cmd_ready. Then drop cmd_valid -> BUSY.
- BUSY: wait for cmd_done -> IDLE. Grants clear on the cycle after cmd_done.
- A cmd_done in IDLE or ISSUE is ignored.
- Write address: cmd_addr = C_M_AXI_TARGET_SLAVE_BASE_ADDR + c*CH_STRIDE + bank[c]*BANK_STRIDE + offset[c].
- offset[c] += BURST_BYTES when the command handshakes.
- Round-robin pointer <= c+1 (mod 3) after a write grant. It is unchanged by read grants.
- Read address: cmd_addr = rd_addr, sampled at grant.
- Frame start for channel c, applied in any state except when channel c is granted and not yet done:
  - if offset[c] != 0: rd_bank[c] <= bank[c], bank[c] toggles
  - offset[c] <= 0
- Frame start while channel c is in flight: latched as pending and applied in the cycle after cmd_done. A second pulse while pending is merged into the first.
- Overrun: if wr_req[c]=1 and offset[c] == FRAME_BYTES, then overrun[c] <= 1 and the channel is skipped. overrun[c] clears only on reset.
- Arithmetic: offset is C_M_AXI_ADDR_WIDTH bits, unsigned. The address sum wraps modulo 2^C_M_AXI_ADDR_WIDTH.
- rst asserted mid-operation: return to IDLE with all reset values next cycle, and drop cmd_valid even in ISSUE. The engine is reset by the same rst.

Test Plan:
- Single writer: wr_req=3'b001 held, cmd_ready=1, cmd_done 4 cycles after each handshake -> cmd_addr sequence 0x10000000, 0x10000100, 0x10000200; cmd_ch=0; cmd_valid one cycle after the request is sampled.
- All writers plus rd_req, no urgent: wr_req=3'b111, rd_req=1 -> grant order ch0, ch1, ch2, ch0… The read is never granted while any writer is eligible. Ch1 first address 0x10800000, ch2 0x11000000.
- Urgent read: rd_urgent=1, rd_req=1, rd_addr=0x12345600 arriving alongside wr_req=3'b111 -> next command is a read: cmd_is_read=1, cmd_ch=3, cmd_addr=0x12345600. Then writes resume at the unchanged RR pointer.
- Bank swap: ch1 writes 3 bursts, then wr_frame_start[1] pulses while ch1 is BUSY -> the swap applies the cycle after cmd_done: rd_bank[1]=0, next ch1 address 0x10C00000. A frame start with offset 0 leaves the bank unchanged.
- Overrun and backpressure: FRAME_BYTES=512, three ch0 requests -> third request sets overrun[0]=1 and issues no command. With cmd_ready=0 for 10 cycles in ISSUE, cmd_addr and cmd_ch stay stable.
- Reset in ISSUE: rst=1 while cmd_valid=1 -> next cycle cmd_valid=0, wr_grant=0, all offsets 0, overrun=0.
